// File: rtl/serial_frame_rx.sv
// rtl/serial_frame_rx.sv - LSB-first serial frame receiver with stop-bit check.
// Define SERIAL_FRAME_RX_PARITY_EN to add an even-parity bit between data and stop.
module serial_frame_rx #(
  parameter int DATA_BITS = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 din,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);

  localparam int CW = $clog2(DATA_BITS + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               r_state;
  logic [CW-1:0]        r_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_ferr;
  logic                 r_perr;
  logic                 r_busy;
  logic                 w_par_bad;

`ifdef SERIAL_FRAME_RX_PARITY_EN
  logic r_par;

  // Even parity: data bits plus the parity bit must XOR to zero.
  assign w_par_bad = ^{r_shift, r_par};

  always_ff @(posedge clock) begin
    if (reset) begin
      r_par <= 1'b0;
    end else if (r_state == S_PARITY) begin
      r_par <= din;
    end
  end
`else
  assign w_par_bad = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_perr  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_perr  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!din) begin
            r_state <= S_DATA;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_DATA: begin
          // New bits enter at the MSB so the first bit received lands at bit 0.
          r_shift <= {din, r_shift[DATA_BITS-1:1]};
          if (r_cnt == CW'(DATA_BITS - 1)) begin
`ifdef SERIAL_FRAME_RX_PARITY_EN
            r_state <= S_PARITY;
`else
            r_state <= S_STOP;
`endif
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_PARITY: begin
          r_state <= S_STOP;
        end
        S_STOP: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          if (!din) begin
            r_ferr <= 1'b1;
          end else if (w_par_bad) begin
            r_perr <= 1'b1;
          end else begin
            r_data  <= r_shift;
            r_valid <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign data_out   = r_data;
  assign valid      = r_valid;
  assign frame_err  = r_ferr;
  assign parity_err = r_perr;
  assign busy       = r_busy;

endmodule

// File: tb/tb_serial_frame_rx.sv
// tb/tb_serial_frame_rx.sv - randomized bench for serial_frame_rx against a frame-level model.
module tb_serial_frame_rx;

  localparam int DB = 8;
`ifdef SERIAL_FRAME_RX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic          clock;
  logic          reset;
  logic          din;
  logic [DB-1:0] data_out;
  logic          valid;
  logic          frame_err;
  logic          parity_err;
  logic          busy;

  int n_vec;
  int n_err;
  int cyc;
  int last_v_cyc;
  logic [DB-1:0] exp_data;

  serial_frame_rx #(.DATA_BITS(DB)) dut (
    .clock      (clock),
    .reset      (reset),
    .din        (din),
    .data_out   (data_out),
    .valid      (valid),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .busy       (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick(input logic b);
    din = b;
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_valid"}, valid, 1'b0);
    check({tag, "_ferr"}, frame_err, 1'b0);
    check({tag, "_perr"}, parity_err, 1'b0);
    check({tag, "_data"}, data_out, exp_data);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(1'b1);
    reset = 1'b0;
    exp_data = '0;
    check_quiet("reset");
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick(1'b1);
      check_quiet("idle");
    end
  endtask

  // Sends start, data LSB first, optional parity bit, stop; then checks the frame outcome.
  task automatic send_frame(input logic [DB-1:0] d, input logic stop_b, input logic par_b);
    logic exp_v, exp_f, exp_p;
    int busy_cycles;
    busy_cycles = 0;
    tick(1'b0);
    busy_cycles += int'(busy);
    for (int i = 0; i < DB; i++) begin
      check("frame_no_strobe", valid | frame_err | parity_err, 1'b0);
      tick(d[i]);
      busy_cycles += int'(busy);
    end
`ifdef SERIAL_FRAME_RX_PARITY_EN
    tick(par_b);
    busy_cycles += int'(busy);
`endif
    tick(stop_b);
    exp_f = !stop_b;
    exp_p = stop_b && (PAR == 1) && ((^d) ^ par_b);
    exp_v = stop_b && !exp_p;
    if (exp_v) exp_data = d;
    check("busy_cycles", busy_cycles, DB + 1 + PAR);
    check("valid", valid, exp_v);
    check("frame_err", frame_err, exp_f);
    check("parity_err", parity_err, exp_p);
    check("data_out", data_out, exp_data);
    check("busy_after_stop", busy, 1'b0);
    if (valid) last_v_cyc = cyc;
  endtask

  initial begin
    int t1, t2;
    logic [DB-1:0] d;
    logic sb, pb;
    n_vec = 0;
    n_err = 0;
    cyc = 0;
    last_v_cyc = -1;
    exp_data = '0;
    reset = 1'b1;
    din = 1'b1;
    tick(1'b1);
    tick(1'b1);
    reset = 1'b0;
    check_quiet("reset_state");

    idle(20);

    send_frame(8'hA5, 1'b1, ^8'hA5);
    tick(1'b1);
    check("valid_one_cycle", valid, 1'b0);

    send_frame(8'h3C, 1'b0, ^8'h3C);
    tick(1'b1);
    check("ferr_one_cycle", frame_err, 1'b0);
    check("data_hold_after_ferr", data_out, 8'hA5);

    send_frame(8'h01, 1'b1, ^8'h01);
    t1 = last_v_cyc;
    send_frame(8'hFE, 1'b1, ^8'hFE);
    t2 = last_v_cyc;
    check("b2b_gap", t2 - t1, DB + 2 + PAR);

    tick(1'b0);
    for (int i = 0; i < 4; i++) tick(i[0]);
    do_reset();
    idle(DB + 4);
    send_frame(8'h5A, 1'b1, ^8'h5A);

`ifdef SERIAL_FRAME_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1);
    send_frame(8'h07, 1'b1, 1'b0);
    tick(1'b1);
    check("perr_one_cycle", parity_err, 1'b0);
`endif

    for (int n = 0; n < 300; n++) begin
      d  = DB'($urandom);
      sb = ($urandom_range(0, 5) != 0);
      pb = (^d) ^ ($urandom_range(0, 4) == 0);
      send_frame(d, sb, pb);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      if ($urandom_range(0, 40) == 0) begin
        tick(1'b0);
        for (int i = 0; i < int'($urandom_range(0, DB - 1)); i++) tick(1'($urandom));
        do_reset();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
